uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver in the uart_clk domain. It captures each completed character from the receiver's parallel output and done strobe, and stores it in a circular FIFO. It presents the stored data to the host logic through a simple read-enable / data-valid interface. It reports occupancy, full and empty status, and a sticky overflow flag for characters lost while full.

Parameters:
DATA_WIDTH, 8, width of each received character (matches receiver data width)
DEPTH, 16, number of FIFO entries; must be a power of 2, minimum 2
ADDR_WIDTH, 4, log2(DEPTH); pointer width

Ports:
uart_clk  input  1  receiver clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
rx_data_in  input  DATA_WIDTH  parallel character from the UART receiver
rx_done_in  input  1  receiver done strobe; character is valid on rx_data_in while high
rd_en  input  1  host read request
overflow_clr  input  1  clears the sticky overflow flag
rd_data  output  DATA_WIDTH  oldest character, registered
rd_valid  output  1  one-cycle pulse; rd_data updated this cycle
fifo_empty  output  1  no entries stored
fifo_full  output  1  DEPTH entries stored
fifo_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky; a character was dropped

Behaviour:
- Reset (rst high at a clock edge):
  - wr_ptr, rd_ptr and count are set to 0.
  - Outputs after reset: rd_data=0, rd_valid=0, fifo_empty=1, fifo_full=0, fifo_count=0, overflow=0.
  - The done-edge register is cleared to 0.
  - Storage array contents are not cleared.
  - Reset mid-operation discards all stored data and any in-flight read.
- Write detection:
  - rx_done_in is registered every cycle (done_q).
  - A write request is generated only when rx_done_in=1 and done_q=0 (rising edge).
  - rx_done_in held high for N cycles produces exactly one write.
  - The data written is rx_data_in sampled in that edge cycle.
  - No write is generated in the cycle after reset if rx_done_in is already high.
- Write acceptance:
  - Accepted if fifo_full=0, or if a read is accepted in the same cycle.
  - Accepted: mem[wr_ptr] <= rx_data_in; wr_ptr increments and wraps modulo DEPTH.
  - Rejected (full, no read): the character is dropped, pointers are unchanged, and overflow is set to 1.
- Read acceptance:
  - Accepted when rd_en=1 and fifo_empty=0.
  - Next cycle: rd_data = mem[rd_ptr at the request] and rd_valid=1 for exactly one cycle; rd_ptr increments and wraps.
  - Latency is 1 cycle from rd_en to rd_valid.
  - rd_en while empty is ignored: rd_valid=0 and rd_data holds its value.
  - There is no fall-through: a write and a read in the same cycle while empty accepts the write only; the read is ignored.
  - rd_data holds its last value between reads.
- Count:
  - count increments on write-only and decrements on read-only.
  - count is unchanged when both are accepted or neither is.
  - fifo_empty = (count==0); fifo_full = (count==DEPTH). Both are derived from the registered count, with no extra latency.
- Overflow:
  - Sticky until overflow_clr=1.
  - If a rejected write and overflow_clr occur in the same cycle, overflow stays 1 (set wins).
- Pointer wrap: a full fill/drain cycle leaves wr_ptr == rd_ptr, and full and empty are distinguished by count.

Test Plan:
- Reset check:
  - Stimulus: assert rst for 2 cycles with rx_done_in=1 and rd_en=1.
  - Required response: fifo_empty=1, fifo_count=0, rd_valid=0, rd_data=0, overflow=0.
  - After release with rx_done_in still high: no write occurs.
- Ordering and latency:
  - Stimulus: pulse rx_done_in one cycle each with 0xA5, 0x3C, 0xFF.
  - Required response: fifo_count=3.
  - Then rd_en for 3 consecutive cycles -> rd_valid on each following cycle with rd_data 0xA5, 0x3C, 0xFF; fifo_empty=1 afterward.
- Level-held done:
  - Stimulus: rx_done_in high for 5 cycles with rx_data_in=0x5A.
  - Required response: exactly one entry; fifo_count=1; the read returns 0x5A.
- Overflow:
  - Stimulus: write 16 bytes 0x00..0x0F, then a 17th byte 0x99.
  - Required response: fifo_full=1, fifo_count=16, overflow=1.
  - Draining returns 0x00..0x0F, and 0x99 never appears.
  - overflow_clr -> overflow=0.
- Simultaneous events:
  - Full FIFO, same-cycle rd_en and write 0x77: read returns the oldest byte, fifo_count stays 16, overflow stays 0, and 0x77 is the last byte drained.
  - Empty FIFO, same-cycle rd_en and write 0x11: no rd_valid, fifo_count=1.
- Wrap and mid-reset:
  - Stimulus: write/read 40 bytes interleaved so the pointers wrap twice.
  - Required response: data is returned in order throughout.
  - Then write 3 bytes and assert rst -> fifo_count=0, empty=1, and a subsequent rd_en gives no rd_valid.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Host-facing bundle of the UART receive FIFO: receiver capture inputs,
// host read handshake and status outputs.
interface uart_rx_fifo_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] rx_data_in;
   logic                  rx_done_in;
   logic                  rd_en;
   logic                  overflow_clr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic [ADDR_WIDTH:0]   fifo_count;
   logic                  overflow;

   modport slave (
      input  rx_data_in, rx_done_in, rd_en, overflow_clr,
      output rd_data, rd_valid, fifo_empty, fifo_full, fifo_count, overflow
   );

   modport master (
      output rx_data_in, rx_done_in, rd_en, overflow_clr,
      input  rd_data, rd_valid, fifo_empty, fifo_full, fifo_count, overflow
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular byte FIFO behind the UART receiver: edge-detected capture of each
// completed character, registered 1-cycle reads, occupancy and sticky overflow.
module uart_rx_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic            uart_clk,
   input  logic            rst,
   uart_rx_fifo_if.slave   bus
);
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q,  count_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  overflow_q, overflow_d;
   logic                  empty_q, full_q;
   logic                  done_q;
   logic                  post_rst_q;
   logic                  wr_req, wr_acc, rd_acc;

   // A done level that is already high when reset releases must not count as a new character.
   always_comb begin
      wr_req     = bus.rx_done_in & ~done_q & ~post_rst_q;
      rd_acc     = bus.rd_en & ~empty_q;
      wr_acc     = wr_req & (~full_q | rd_acc);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_acc;
      overflow_d = overflow_q;

      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_acc) begin
         rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
         rd_data_d = mem_q[rd_ptr_q];
      end

      if (wr_acc && !rd_acc)      count_d = count_q + CNT_W'(1);
      else if (rd_acc && !wr_acc) count_d = count_q - CNT_W'(1);

      // Dropped character takes priority over a same-cycle clear.
      if (wr_req && !wr_acc)         overflow_d = 1'b1;
      else if (bus.overflow_clr)     overflow_d = 1'b0;
   end

   always_ff @(posedge uart_clk) begin
      post_rst_q <= rst;
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         overflow_q <= overflow_d;
         empty_q    <= (count_d == CNT_W'(0));
         full_q     <= (count_d == CNT_W'(DEPTH));
         done_q     <= bus.rx_done_in;
      end
   end

   // Storage is deliberately left uninitialised across reset.
   always_ff @(posedge uart_clk) begin
      if (!rst && wr_acc) mem_q[wr_ptr_q] <= bus.rx_data_in;
   end

   assign bus.rd_data    = rd_data_q;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.fifo_empty = empty_q;
   assign bus.fifo_full  = full_q;
   assign bus.fifo_count = count_q;
   assign bus.overflow   = overflow_q;
endmodule
